// File: rtl/cache_ctrl_if.sv
// cache_ctrl_if -- signal bundle between the cache controller and its
// surroundings: the CPU request port, the data-array port and the
// backing-store bus.
//
// Handshakes:
//   CPU side: a request transfers on a rising edge where i_req && o_ready.
//     o_ready is high only when the controller is idle. A request presented
//     while o_ready is low is dropped, not queued. Each accepted request
//     ends with exactly one o_done pulse, unless reset abandons it.
//   Bus side: o_bus_req with o_bus_we/o_bus_addr/o_bus_wdata is held stable
//     until i_bus_ack is sampled high on a rising edge. The controller drops
//     o_bus_req the cycle after that edge. i_bus_ack is ignored while
//     o_bus_req is low, and it may be high in the first cycle of a request.
//
// Groups:
//   i_req/i_we/i_addr/i_wdata/o_ready/o_done/o_rdata    CPU port
//   o_mem_write/o_mem_addr/o_mem_wdata/i_mem_rdata      data array port
//   o_bus_req/o_bus_we/o_bus_addr/o_bus_wdata/
//   i_bus_ack/i_bus_rdata                               backing-store bus
//   dbg_state                                           controller FSM state
//
// Modports: slave = controller side, master = environment side.
interface cache_ctrl_if #(
    parameter int INDEX_W = 8
);
    logic               i_req;
    logic               i_we;
    logic [31:0]        i_addr;
    logic [31:0]        i_wdata;
    logic               o_ready;
    logic               o_done;
    logic [31:0]        o_rdata;

    logic               o_mem_write;
    logic [INDEX_W-1:0] o_mem_addr;
    logic [31:0]        o_mem_wdata;
    logic [31:0]        i_mem_rdata;

    logic               o_bus_req;
    logic               o_bus_we;
    logic [31:0]        o_bus_addr;
    logic [31:0]        o_bus_wdata;
    logic               i_bus_ack;
    logic [31:0]        i_bus_rdata;

    logic [2:0]         dbg_state;

    modport slave (
        input  i_req, i_we, i_addr, i_wdata, i_mem_rdata, i_bus_ack, i_bus_rdata,
        output o_ready, o_done, o_rdata, o_mem_write, o_mem_addr, o_mem_wdata,
        output o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, dbg_state
    );

    modport master (
        output i_req, i_we, i_addr, i_wdata, i_mem_rdata, i_bus_ack, i_bus_rdata,
        input  o_ready, o_done, o_rdata, o_mem_write, o_mem_addr, o_mem_wdata,
        input  o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, dbg_state
    );
endinterface

// File: rtl/cache_ctrl.sv
// cache_ctrl -- direct-mapped, write-through, no-write-allocate cache
// controller. Tags and valid bits live in flops here; the data words live in
// an external array whose read data is combinational from o_mem_addr and
// which writes during the low phase of the clock.
//
// Ports:
//   i_clk     single clock, all state changes on the rising edge
//   i_nreset  asynchronous active-low reset
//   io        cache_ctrl_if.slave: CPU port, data array port, backing bus,
//             FSM state (dbg_state: 0 IDLE, 1 LOOKUP, 2 FILL, 3 REFILL_WR,
//             4 WRITE)
//
// Address split: [1:0] ignored, index = [INDEX_W+1:2], tag = [31:INDEX_W+2].
module cache_ctrl #(
    parameter int INDEX_W = 8
) (
    input logic        i_clk,
    input logic        i_nreset,
    cache_ctrl_if.slave io
);
    localparam int TAG_W = 30 - INDEX_W;
    localparam int DEPTH = 2 ** INDEX_W;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        FILL      = 3'd2,
        REFILL_WR = 3'd3,
        WRITE     = 3'd4
    } state_t;

    state_t             state;
    logic               req_we;
    logic [31:2]        req_addr;
    logic [31:0]        req_wdata;
    logic [TAG_W-1:0]   tag_q [DEPTH];
    logic [DEPTH-1:0]   valid_q;

    logic [INDEX_W-1:0] req_index;
    logic [TAG_W-1:0]   req_tag;
    logic               hit;
    logic               unused_byte_bits;

    assign req_index = req_addr[INDEX_W+1:2];
    assign req_tag   = req_addr[31:INDEX_W+2];
    assign hit       = valid_q[req_index] && (tag_q[req_index] == req_tag);

    // Byte offset within a word has no meaning to a word-wide cache.
    assign unused_byte_bits = ^io.i_addr[1:0];

    assign io.o_ready   = (state == IDLE);
    assign io.dbg_state = state;

    always_ff @(posedge i_clk or negedge i_nreset) begin
        if (!i_nreset) begin
            state          <= IDLE;
            req_we         <= 1'b0;
            req_addr       <= '0;
            req_wdata      <= '0;
            valid_q        <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
            end
            io.o_done      <= 1'b0;
            io.o_rdata     <= '0;
            io.o_mem_write <= 1'b0;
            io.o_mem_addr  <= '0;
            io.o_mem_wdata <= '0;
            io.o_bus_req   <= 1'b0;
            io.o_bus_we    <= 1'b0;
            io.o_bus_addr  <= '0;
            io.o_bus_wdata <= '0;
        end else begin
            // Single-cycle pulses unless a state below re-asserts them.
            io.o_done      <= 1'b0;
            io.o_mem_write <= 1'b0;

            case (state)
                IDLE: begin
                    if (io.i_req) begin
                        req_we        <= io.i_we;
                        req_addr      <= io.i_addr[31:2];
                        req_wdata     <= io.i_wdata;
                        // The array address is registered here so the array
                        // read data is ready throughout LOOKUP.
                        io.o_mem_addr <= io.i_addr[INDEX_W+1:2];
                        state         <= LOOKUP;
                    end
                end

                LOOKUP: begin
                    if (req_we) begin
                        // Write-through: every write goes to the bus; the
                        // array is only updated when the line is present.
                        io.o_bus_req   <= 1'b1;
                        io.o_bus_we    <= 1'b1;
                        io.o_bus_addr  <= {req_addr, 2'b00};
                        io.o_bus_wdata <= req_wdata;
                        if (hit) begin
                            io.o_mem_write <= 1'b1;
                            io.o_mem_wdata <= req_wdata;
                        end
                        state <= WRITE;
                    end else if (hit) begin
                        io.o_rdata <= io.i_mem_rdata;
                        io.o_done  <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        io.o_bus_req  <= 1'b1;
                        io.o_bus_we   <= 1'b0;
                        io.o_bus_addr <= {req_addr, 2'b00};
                        state         <= FILL;
                    end
                end

                FILL: begin
                    if (io.i_bus_ack) begin
                        io.o_bus_req       <= 1'b0;
                        io.o_mem_write     <= 1'b1;
                        io.o_mem_wdata     <= io.i_bus_rdata;
                        io.o_rdata         <= io.i_bus_rdata;
                        io.o_done          <= 1'b1;
                        // A conflicting line at this index is simply replaced.
                        tag_q[req_index]   <= req_tag;
                        valid_q[req_index] <= 1'b1;
                        state              <= REFILL_WR;
                    end
                end

                REFILL_WR: begin
                    state <= IDLE;
                end

                WRITE: begin
                    if (io.i_bus_ack) begin
                        io.o_bus_req <= 1'b0;
                        io.o_bus_we  <= 1'b0;
                        io.o_rdata   <= '0;
                        io.o_done    <= 1'b1;
                        state        <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 SHALL have parameter INDEX_W, default 8, meaning index bits (data array depth = 2**INDEX_W words); TAG_W = 30-INDEX_W derived internally.
REQ-002 SHALL have port i_clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port i_nreset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port i_req  input  1  CPU request; accepted when i_req && o_ready at a rising edge.
REQ-005 SHALL have port i_we  input  1  CPU request is write (1) or read (0).
REQ-006 SHALL have port i_addr  input  32  CPU byte address; [1:0] ignored; index = [INDEX_W+1:2], tag = [31:INDEX_W+2].
REQ-007 SHALL have port i_wdata  input  32  CPU write data.
REQ-008 SHALL have port o_ready  output  1  controller idle, can accept a request.
REQ-009 SHALL have port o_done  output  1  one-cycle completion pulse for reads and writes.
REQ-010 SHALL have port o_rdata  output  32  read data, valid when o_done of a read.
REQ-011 SHALL have port o_mem_write  output  1  data array write enable.
REQ-012 SHALL have port o_mem_addr  output  INDEX_W  data array word index.
REQ-013 SHALL have port o_mem_wdata  output  32  data array write data.
REQ-014 SHALL have port i_mem_rdata  input  32  data array read data (combinational from o_mem_addr).
REQ-015 SHALL have ports o_bus_req/o_bus_we (output 1), o_bus_addr/o_bus_wdata (output 32), i_bus_ack (input 1), i_bus_rdata (input 32): backing-store bus.

Function
REQ-016 SHALL implement a direct-mapped, write-through, no-write-allocate controller with FSM states IDLE, LOOKUP, FILL, REFILL_WR, WRITE.
REQ-017 SHALL hold a TAG_W tag and 1 valid bit per index in internal flops.
REQ-018 SHALL drive o_ready=1 only in IDLE; i_req while o_ready=0 is ignored, not queued.
REQ-019 SHALL on acceptance latch i_we/i_addr/i_wdata and go IDLE->LOOKUP; o_mem_addr = latched index from LOOKUP until return to IDLE.
REQ-020 SHALL in LOOKUP on read hit (valid && tag equal) register i_mem_rdata to o_rdata and pulse o_done next cycle (accept edge N, o_done at N+2), returning to IDLE.
REQ-021 SHALL on read miss go to FILL: o_bus_req=1, o_bus_we=0, o_bus_addr = latched address with [1:0]=0, held stable until i_bus_ack sampled high.
REQ-022 SHALL on ack in FILL go to REFILL_WR for exactly one cycle: o_mem_write=1, o_mem_wdata=i_bus_rdata captured at ack, tag written, valid set, o_rdata=same data, o_done=1; then IDLE.
REQ-023 SHALL on any write go LOOKUP->WRITE: bus write of latched address/data held until ack; on hit o_mem_write=1 with o_mem_wdata=latched data in the first WRITE cycle only; on miss o_mem_write stays 0 and tag/valid are unchanged.
REQ-024 SHALL on ack in WRITE pulse o_done next cycle with o_rdata=0 and return to IDLE.
REQ-025 SHALL drop o_bus_req the cycle after ack; i_bus_ack while o_bus_req=0 is ignored; ack in the first request cycle is legal.
REQ-026 SHALL drive o_mem_write, o_mem_addr, o_mem_wdata from registers only, changing only at rising edges, since the array writes during clock-low.
REQ-027 SHALL replace a conflicting tag on refill (same index, different tag) unconditionally.

Reset
REQ-028 SHALL, while i_nreset=0, immediately force state IDLE, all valid bits 0, o_done/o_mem_write/o_bus_req/o_bus_we=0, o_rdata/o_mem_addr/o_mem_wdata/o_bus_addr/o_bus_wdata=0, o_ready=1.
REQ-029 SHALL abandon any in-flight transaction on reset with no o_done; the data array contents are not cleared.

Verification
REQ-030 Reset, read 0x00000040 -> FILL with bus addr 0x40, ack data 0xDEADBEEF -> o_mem_write idx 0x10, o_done, o_rdata 0xDEADBEEF; reread -> o_done at N+2, no o_bus_req.
REQ-031 After REQ-030, read 0x00000440 -> miss, refill idx 0x10; then read 0x00000040 -> miss again.
REQ-032 Write 0x00000040 data 0x12345678 after fill -> bus write, o_mem_write idx 0x10 one cycle; read 0x40 -> hit, 0x12345678.
REQ-033 Write miss 0x00000080 data 0x55 -> bus write only, o_mem_write stays 0; read 0x80 -> miss.
REQ-034 Ack delayed 5 cycles with i_req held high -> bus signals stable, o_ready=0, extra requests ignored.
REQ-035 Reset asserted in FILL -> o_bus_req falls asynchronously, no o_done; read 0x40 after release -> miss.
